// File: rtl/id_pipe_stage.sv
// Decode-stage register file, load-use hazard detection and ID/EX pipeline register.
// A load occupies a pending slot for LOAD_LAT cycles; dependents stall until it drains.
module id_pipe_stage #(
    parameter  int XLEN     = 32,
    parameter  int NREG     = 32,
    parameter  int CTRL_W   = 16,
    parameter  int LOAD_LAT = 1,
    localparam int AW       = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr_id,
    input  logic [XLEN-1:0]   pc_id,
    input  logic [CTRL_W-1:0] ctrl_id,
    input  logic              is_load_id,
    input  logic              use_rs1_id,
    input  logic              use_rs2_id,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [AW-1:0]     ex_rs1,
    output logic [AW-1:0]     ex_rs2,
    output logic [AW-1:0]     ex_rd,
    output logic              ex_is_load,
    output logic [31:0]       stall_count
);

    logic [XLEN-1:0]     rf [NREG];
    logic [AW-1:0]       rs1, rs2, rd;
    logic [XLEN-1:0]     rs1_data, rs2_data;
    logic [LOAD_LAT-1:0] p_valid;
    logic [AW-1:0]       p_rd [LOAD_LAT];
    logic                rs1_hit, rs2_hit;
    logic                hazard, accepted, stall_inc;
    logic                unused_instr_bits;

    assign rs1 = instr_id[15 +: AW];
    assign rs2 = instr_id[20 +: AW];
    assign rd  = instr_id[7 +: AW];
    assign unused_instr_bits = ^instr_id;

    // Same-cycle write-back is forwarded so the captured operand is never stale.
    always_comb begin
        rs1_data = rf[rs1];
        rs2_data = rf[rs2];
        if (rs1 == '0)
            rs1_data = '0;
        else if (wb_we && wb_rd == rs1)
            rs1_data = wb_data;
        if (rs2 == '0)
            rs2_data = '0;
        else if (wb_we && wb_rd == rs2)
            rs2_data = wb_data;
    end

    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        for (int k = 0; k < LOAD_LAT; k++) begin
            if (p_valid[k] && p_rd[k] == rs1) rs1_hit = 1'b1;
            if (p_valid[k] && p_rd[k] == rs2) rs2_hit = 1'b1;
        end
        hazard = in_valid && ((use_rs1_id && rs1 != '0 && rs1_hit) ||
                              (use_rs2_id && rs2 != '0 && rs2_hit));
    end

    // A flush overrides a hazard: the killed instruction must not hold up fetch.
    assign in_ready  = !hazard || flush;
    assign accepted  = in_valid && in_ready && !flush;
    assign stall_inc = hazard && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (wb_we && wb_rd != '0) begin
            rf[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid <= '0;
            for (int k = 0; k < LOAD_LAT; k++) p_rd[k] <= '0;
        end else begin
            p_valid[0] <= accepted && is_load_id && rd != '0;
            p_rd[0]    <= rd;
            for (int k = 1; k < LOAD_LAT; k++) begin
                p_valid[k] <= p_valid[k-1];
                p_rd[k]    <= p_rd[k-1];
            end
        end
    end

    // Bubbles clear only the fields that could trigger side effects downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_ctrl     <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_is_load  <= 1'b0;
        end else if (accepted) begin
            ex_valid    <= 1'b1;
            ex_pc       <= pc_id;
            ex_ctrl     <= ctrl_id;
            ex_rs1_data <= rs1_data;
            ex_rs2_data <= rs2_data;
            ex_rs1      <= rs1;
            ex_rs2      <= rs2;
            ex_rd       <= rd;
            ex_is_load  <= is_load_id;
        end else begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= '0;
            ex_rd       <= '0;
            ex_is_load  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= '0;
        else if (stall_inc && stall_count != '1)
            stall_count <= stall_count + 32'd1;
    end

endmodule
